// File: rtl/cpu_sequencer_pkg.sv
// Shared types and constants for the accumulator CPU control path.
package cpu_sequencer_pkg;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    // Address mux select: S1 routes the PC, S0 routes the IR operand.
    localparam logic S0 = 1'b0;
    localparam logic S1 = 1'b1;

    function automatic logic is_aluop(input opcode_t op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational strobe decode from the current phase, opcode, zero flag and halt state.
module cpu_ctrl_decode
    import cpu_sequencer_pkg::*;
(
    input  phase_t  phase,
    input  opcode_t opcode,
    input  logic    zero,
    input  logic    halted,
    output logic    sel,
    output logic    mem_rd,
    output logic    mem_wr,
    output logic    load_ir,
    output logic    load_ac,
    output logic    load_pc,
    output logic    inc_pc,
    output logic    halt
);

    logic aluop;

    assign aluop = is_aluop(opcode);

    always_comb begin
        sel     = S0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        load_ir = 1'b0;
        load_ac = 1'b0;
        load_pc = 1'b0;
        inc_pc  = 1'b0;
        halt    = 1'b0;
        if (halted) begin
            halt = 1'b1;
        end else begin
            case (phase)
                INST_ADDR: sel = S1;
                INST_FETCH: begin
                    sel    = S1;
                    mem_rd = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel     = S1;
                    mem_rd  = 1'b1;
                    load_ir = 1'b1;
                end
                OP_ADDR: begin
                    halt   = (opcode == HLT);
                    inc_pc = 1'b1;
                end
                OP_FETCH: mem_rd = aluop;
                ALU_OP: begin
                    mem_rd  = aluop;
                    load_ac = aluop;
                    inc_pc  = (opcode == SKZ) && zero;
                    load_pc = (opcode == JMP);
                end
                STORE: begin
                    mem_rd  = aluop;
                    load_ac = aluop;
                    inc_pc  = (opcode == JMP);
                    load_pc = (opcode == JMP);
                    mem_wr  = (opcode == STO);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Eight-phase fetch/execute sequencer with memory-ready stall and sticky halt.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter bit STALL_EN = 1'b1
) (
    input  logic    clk,
    input  logic    rst,
    input  opcode_t opcode,
    input  logic    zero,
    input  logic    mem_ready,
    output logic    sel,
    output logic    mem_rd,
    output logic    mem_wr,
    output logic    load_ir,
    output logic    load_ac,
    output logic    load_pc,
    output logic    inc_pc,
    output logic    halt,
    output phase_t  phase
);

    phase_t phase_q, phase_d;
    logic   halted_q, halted_d;
    logic   wait_mem;

    assign wait_mem = STALL_EN && !mem_ready;

    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        if (!halted_q) begin
            case (phase_q)
                INST_ADDR:  phase_d = INST_FETCH;
                INST_FETCH: phase_d = wait_mem ? INST_FETCH : INST_LOAD;
                INST_LOAD:  phase_d = IDLE;
                IDLE:       phase_d = OP_ADDR;
                OP_ADDR: begin
                    // A halt freezes the phase here so the debug port shows where it stopped.
                    if (opcode == HLT) halted_d = 1'b1;
                    else               phase_d  = OP_FETCH;
                end
                OP_FETCH:   phase_d = (wait_mem && is_aluop(opcode)) ? OP_FETCH : ALU_OP;
                ALU_OP:     phase_d = STORE;
                STORE:      phase_d = INST_ADDR;
                default:    phase_d = INST_ADDR;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    assign phase = phase_q;

    cpu_ctrl_decode u_decode (
        .phase   (phase_q),
        .opcode  (opcode),
        .zero    (zero),
        .halted  (halted_q),
        .sel     (sel),
        .mem_rd  (mem_rd),
        .mem_wr  (mem_wr),
        .load_ir (load_ir),
        .load_ac (load_ac),
        .load_pc (load_pc),
        .inc_pc  (inc_pc),
        .halt    (halt)
    );

    a_rd_wr_exclusive: assert property (@(posedge clk) disable iff (rst) !(mem_rd && mem_wr));
    a_load_ir_sel:     assert property (@(posedge clk) disable iff (rst) load_ir |-> (sel == S1));

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed scenarios plus random traffic against a phase model.
module tb_cpu_sequencer;
    import cpu_sequencer_pkg::*;

    logic    clk = 1'b0;
    logic    rst;
    opcode_t opcode;
    logic    zero;
    logic    mem_ready;
    logic    sel, mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, halt;
    phase_t  phase;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: phase as a plain integer 0..7 plus a halted bit.
    int m_ph     = 0;
    bit m_halted = 1'b0;

    // Strobe pulse counters over the current instruction, sampled from the DUT.
    int cnt_inc, cnt_wr, cnt_ldpc, cnt_ldac;

    cpu_sequencer #(.STALL_EN(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .sel       (sel),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .load_ir   (load_ir),
        .load_ac   (load_ac),
        .load_pc   (load_pc),
        .inc_pc    (inc_pc),
        .halt      (halt),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    // Expected {sel,mem_rd,mem_wr,load_ir,load_ac,load_pc,inc_pc,halt,phase[2:0]}.
    function automatic logic [10:0] expect_vec(int ph, opcode_t op, logic z, bit h);
        bit   alu = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
        logic s = 0, rd = 0, wr = 0, ir = 0, ac = 0, pc = 0, inc = 0, hl = 0;
        logic [2:0] p = ph[2:0];
        if (h) return {8'b0000_0001, 3'd4};
        case (ph)
            0: s = 1;
            1: begin s = 1; rd = 1; end
            2, 3: begin s = 1; rd = 1; ir = 1; end
            4: begin hl = (op == HLT); inc = 1; end
            5: rd = alu;
            6: begin rd = alu; ac = alu; inc = (op == SKZ) && z; pc = (op == JMP); end
            7: begin rd = alu; ac = alu; inc = (op == JMP); pc = (op == JMP); wr = (op == STO); end
            default: ;
        endcase
        return {s, rd, wr, ir, ac, pc, inc, hl, p};
    endfunction

    function automatic logic [10:0] observed();
        return {sel, mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, halt, phase};
    endfunction

    task automatic check_vec(input string tag, input logic [10:0] exp);
        logic [10:0] obs;
        obs = observed();
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check at negedge, advance model at posedge.
    task automatic cycle(input opcode_t op, input logic z, input logic rdy, input string tag);
        bit alu;
        opcode    = op;
        zero      = z;
        mem_ready = rdy;
        @(negedge clk);
        check_vec(tag, expect_vec(m_ph, op, z, m_halted));
        cnt_inc  += int'(inc_pc);
        cnt_wr   += int'(mem_wr);
        cnt_ldpc += int'(load_pc);
        cnt_ldac += int'(load_ac);
        @(posedge clk);
        alu = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
        if (!m_halted) begin
            if (m_ph == 4 && op == HLT)            m_halted = 1'b1;
            else if (m_ph == 1 && !rdy)            ;
            else if (m_ph == 5 && alu && !rdy)     ;
            else                                   m_ph = (m_ph + 1) % 8;
        end
        #1;
    endtask

    // Runs one whole instruction from INST_ADDR, stalling INST_FETCH for 'stalls' cycles.
    task automatic run_instr(input opcode_t op, input logic z, input int stalls, input string tag);
        int   n = 0;
        int   left = stalls;
        logic rdy;
        cnt_inc = 0; cnt_wr = 0; cnt_ldpc = 0; cnt_ldac = 0;
        do begin
            rdy = !(m_ph == 1 && left > 0);
            if (!rdy) left--;
            cycle(op, z, rdy, tag);
            n++;
        end while (phase != INST_ADDR && n < 40);
        check_int({tag, "_len"}, n, 8 + stalls);
    endtask

    initial begin
        rst = 1'b1; opcode = LDA; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_vec("reset", {8'b1000_0000, 3'd0});
        rst = 1'b0;
        @(posedge clk); #1;
        m_ph = 1;

        // Finish the partial instruction, then the directed set.
        while (m_ph != 0) cycle(LDA, 1'b0, 1'b1, "warmup");

        run_instr(LDA, 1'b0, 0, "lda");
        check_int("lda_ldac", cnt_ldac, 2);
        check_int("lda_wr", cnt_wr, 0);
        run_instr(STO, 1'b0, 0, "sto");
        check_int("sto_wr", cnt_wr, 1);
        run_instr(SKZ, 1'b1, 0, "skz_z1");
        check_int("skz_z1_inc", cnt_inc, 2);
        run_instr(SKZ, 1'b0, 0, "skz_z0");
        check_int("skz_z0_inc", cnt_inc, 1);
        run_instr(JMP, 1'b0, 0, "jmp");
        check_int("jmp_inc", cnt_inc, 2);
        check_int("jmp_ldpc", cnt_ldpc, 2);
        check_int("jmp_ldac", cnt_ldac, 0);
        run_instr(ADD, 1'b1, 3, "stall3");

        // Random traffic: opcode changes only at instruction boundaries.
        for (int i = 0; i < 300; i++) begin
            if (m_ph == 0) opcode = opcode_t'($urandom_range(1, 7));
            cycle(opcode, 1'($urandom), 1'($urandom_range(0, 9) < 7), "random");
        end
        while (m_ph != 0) cycle(opcode, 1'b0, 1'b1, "drain");

        // Halt, hold for 22 cycles, then asynchronous reset mid-halt.
        for (int i = 0; i < 27; i++) cycle(HLT, 1'($urandom), 1'($urandom), "halt");
        check_int("halted_model", int'(m_halted), 1);
        #2;
        rst = 1'b1;
        #1;
        check_vec("async_rst", {8'b1000_0000, 3'd0});
        m_ph = 0; m_halted = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        m_ph = 1;
        while (m_ph != 0) cycle(LDA, 1'b0, 1'b1, "post_rst");
        run_instr(XOR, 1'b0, 0, "after_halt");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control unit for the accumulator RISC CPU.
- Steps the eight-phase fetch/execute cycle and decodes the current opcode into the datapath strobes.
- Drives the select line of the address multiplexer:
  - sel=1 routes the program counter to the memory address.
  - sel=0 routes the IR operand field to the memory address.
- Adds a memory-ready stall and a sticky halt state.

Parameters:
- STALL_EN, 1, 1 = phases INST_FETCH and OP_FETCH (the latter only for ALU ops) wait for mem_ready; 0 = mem_ready ignored.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  opcode_t (3)  IR opcode field. Stable from INST_LOAD onward.
- zero  input  1  accumulator-zero flag.
- mem_ready  input  1  memory read data valid this cycle.
- sel  output  1  address mux select (1 = PC, 0 = IR operand).
- mem_rd  output  1  memory read strobe.
- mem_wr  output  1  memory write strobe.
- load_ir  output  1  instruction register load.
- load_ac  output  1  accumulator load.
- load_pc  output  1  PC load (jump).
- inc_pc  output  1  PC increment.
- halt  output  1  CPU halted, sticky.
- phase  output  phase_t (3)  current phase, for debug.

Behaviour:
- Phase register values: INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE. Wraps STORE -> INST_ADDR.
- Sticky halted flag, separate from the phase register.
- Reset: phase=INST_ADDR, halted=0. All outputs 0 except sel=1. Reset mid-cycle aborts the instruction; no strobe may glitch high while rst=1.
- Advance: phase moves to the next phase on each clk edge, except:
  - Stall in INST_FETCH while STALL_EN && !mem_ready.
  - Stall in OP_FETCH while STALL_EN && ALUOP && !mem_ready.
  - During a stall all outputs hold their phase values.
- Halt: in OP_ADDR with opcode==HLT, the halted flag sets at the clock edge. Phase then freezes at OP_ADDR until rst.
  - While halted: halt=1, all other strobes 0, sel=0.
- ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Output decode is combinational from the phase register plus opcode/zero. Strobes not listed for a phase are 0.
  - INST_ADDR: sel=1.
  - INST_FETCH: sel=1, mem_rd=1.
  - INST_LOAD: sel=1, mem_rd=1, load_ir=1.
  - IDLE: sel=1, mem_rd=1, load_ir=1.
  - OP_ADDR: halt=(opcode==HLT), inc_pc=1.
  - OP_FETCH: mem_rd=ALUOP.
  - ALU_OP: mem_rd=ALUOP, load_ac=ALUOP, inc_pc=(opcode==SKZ && zero), load_pc=(opcode==JMP).
  - STORE: mem_rd=ALUOP, load_ac=ALUOP, inc_pc=(opcode==JMP), load_pc=(opcode==JMP), mem_wr=(opcode==STO).
- Latency: 8 cycles per instruction with no stalls. Each stall cycle adds 1 cycle.
- Simultaneous events:
  - SKZ with zero=1 gives a single extra inc_pc pulse in ALU_OP only.
  - mem_ready is ignored outside the two fetch phases.
- Invariants (assertions):
  - mem_rd and mem_wr never both 1.
  - load_ir implies sel=1.
  - Unreachable phase encoding returns to INST_ADDR.

Decomposition:
- typedefs package additions:
  - opcode_t enum: HLT=0, SKZ, ADD, AND, XOR, LDA, STO, JMP.
  - phase_t enum, 3-bit, in the order listed above.
  - Select constants S0/S1, shared with the address multiplexer.
- One natural sub-module: cpu_ctrl_decode, purely combinational (phase, opcode, zero, halted -> strobes).
- Phase/halt registers and stall logic live in cpu_sequencer.

Test Plan:
- Reset then release, opcode=LDA, mem_ready=1 -> phases 0..7 in 8 cycles. mem_rd high in phases 1-3 and 5-7; load_ir in 2-3; inc_pc in 4; load_ac in 6-7; mem_wr never.
- opcode=STO -> mem_wr=1 only in STORE. mem_rd=0 in OP_FETCH/ALU_OP/STORE. sel=0 from OP_ADDR to STORE.
- opcode=SKZ with zero=1 -> inc_pc in OP_ADDR and ALU_OP (2 pulses). With zero=0 -> 1 pulse.
- opcode=JMP -> load_pc=1 in ALU_OP and STORE; inc_pc=1 in OP_ADDR and STORE; load_ac never.
- STALL_EN=1, mem_ready low for 3 cycles in INST_FETCH -> phase holds with mem_rd=1 for 4 cycles total; instruction takes 11 cycles.
- opcode=HLT -> halt rises in OP_ADDR and stays 1 for 20+ cycles, all strobes 0. rst pulse mid-halt -> phase=INST_ADDR, halt=0, sel=1 asynchronously.
